// File: rtl/linear_layer_srl_fifo_pkg.sv
// Shared sizing helpers for the Linear_Layer SRL FIFO family.
package linear_layer_fifo_pkg;

    // Ceiling log2; clog2(1) is 0.
    function automatic int clog2(input int value);
        int result;
        int v;
        result = 0;
        v = value - 1;
        while (v > 0) begin
            result = result + 1;
            v = v >> 1;
        end
        return result;
    endfunction

    // Read-address width for a store of 'depth' entries, never narrower than one bit.
    function automatic int addr_width(input int depth);
        return (clog2(depth) < 1) ? 1 : clog2(depth);
    endfunction

    // Occupancy width: must hold DEPTH plus the output-register word.
    function automatic int cnt_width(input int depth);
        return clog2(depth + 2);
    endfunction

endpackage

// File: rtl/linear_layer_srl_store.sv
// Shift-register storage: new words enter at entry 0, the oldest word sits at
// the highest occupied index and is read through a combinational mux.
module linear_layer_srl_store
    import linear_layer_fifo_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 17,
    localparam int ADDR_WIDTH = addr_width(DEPTH)
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [DATA_WIDTH-1:0] din,
    output logic [DATA_WIDTH-1:0] dout
);

    logic [DATA_WIDTH-1:0] entry_q [DEPTH];

    // Shift the whole chain by one on every write; contents are deliberately not reset.
    always_ff @(posedge clk) begin
        if (we) begin
            entry_q[0] <= din;
            for (int i = 1; i < DEPTH; i++) begin
                entry_q[i] <= entry_q[i-1];
            end
        end
    end

    assign dout = entry_q[addr];

endmodule

// File: rtl/linear_layer_srl_fifo.sv
// SRL FIFO between quantised linear-layer stages: occupancy counter, full /
// almost-full / empty handshake, live word count and optional output register.
module linear_layer_srl_fifo
    import linear_layer_fifo_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 17,
    parameter int AF_MARGIN  = 2,
    parameter int OUT_REG    = 0,
    localparam int ADDR_WIDTH = addr_width(DEPTH),
    localparam int CNT_WIDTH  = cnt_width(DEPTH)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  if_write_ce,
    input  logic                  if_write,
    input  logic [DATA_WIDTH-1:0] if_din,
    output logic                  if_full_n,
    output logic                  if_almost_full_n,
    input  logic                  if_read_ce,
    input  logic                  if_read,
    output logic [DATA_WIDTH-1:0] if_dout,
    output logic                  if_empty_n,
    output logic [CNT_WIDTH-1:0]  if_num_data_valid
);

    localparam logic [CNT_WIDTH-1:0] FULL_LEVEL = CNT_WIDTH'(DEPTH);
    localparam logic [CNT_WIDTH-1:0] AF_LEVEL   = CNT_WIDTH'(DEPTH - AF_MARGIN);

    logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
    logic [ADDR_WIDTH-1:0] rdAddr;
    logic [DATA_WIDTH-1:0] srlDout;
    logic                  push, pop, drain, outValid;

    // Flags come straight from the registered count so no request input reaches them.
    assign if_full_n        = (cnt_q != FULL_LEVEL);
    assign if_almost_full_n = (cnt_q < AF_LEVEL);

    assign push   = if_write & if_write_ce & if_full_n;
    assign pop    = if_read & if_read_ce & if_empty_n;
    assign rdAddr = (cnt_q == '0) ? '0 : ADDR_WIDTH'(cnt_q - CNT_WIDTH'(1));

    linear_layer_srl_store #(
        .DATA_WIDTH(DATA_WIDTH),
        .DEPTH     (DEPTH)
    ) uStore (
        .clk (clk),
        .we  (push),
        .addr(rdAddr),
        .din (if_din),
        .dout(srlDout)
    );

    // Count moves only when exactly one of push / drain happens.
    always_comb begin
        cnt_d = cnt_q;
        if (push && !drain) begin
            cnt_d = cnt_q + CNT_WIDTH'(1);
        end else if (drain && !push) begin
            cnt_d = cnt_q - CNT_WIDTH'(1);
        end
    end

    // Occupancy register, cleared synchronously.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    if (OUT_REG != 0) begin : gOutReg
        logic                  outValid_q, outValid_d;
        logic [DATA_WIDTH-1:0] outData_q, outData_d;

        // Refill the output word whenever it is empty or being consumed this cycle.
        always_comb begin
            drain      = (cnt_q != '0) && (!outValid_q || pop);
            outValid_d = outValid_q;
            outData_d  = outData_q;
            if (drain) begin
                outValid_d = 1'b1;
                outData_d  = srlDout;
            end else if (pop) begin
                outValid_d = 1'b0;
            end
        end

        // Output register stage, cleared synchronously.
        always_ff @(posedge clk) begin
            if (reset) begin
                outValid_q <= 1'b0;
                outData_q  <= '0;
            end else begin
                outValid_q <= outValid_d;
                outData_q  <= outData_d;
            end
        end

        assign outValid   = outValid_q;
        assign if_empty_n = outValid_q;
        assign if_dout    = outData_q;
    end else begin : gDirect
        assign drain      = pop;
        assign outValid   = 1'b0;
        assign if_empty_n = (cnt_q != '0);
        assign if_dout    = srlDout;
    end

    assign if_num_data_valid = cnt_q + CNT_WIDTH'(outValid);

endmodule

// File: doc/linear_layer_srl_fifo.md
# linear_layer_srl_fifo

Parametrised shift-register (SRL) FIFO for stream channels between Linear_Layer stages (e.g. i4xi4 quantised activations, 8-bit packed words). Extends the plain SRL store with occupancy tracking, full/empty handshake, an almost-full watermark, a live data count, and an optional registered-output mode for timing closure on long inter-stage routes. Sits between the producer and consumer tasks of each quantised linear layer.

## Interface
- DATA_WIDTH, 8, word width in bits (≥1)
- DEPTH, 17, SRL entries (≥2)
- AF_MARGIN, 2, almost_full_n deasserts when SRL occupancy ≥ DEPTH−AF_MARGIN (0 ≤ AF_MARGIN < DEPTH)
- OUT_REG, 0, 0 = combinational read from SRL; 1 = extra output register, capacity DEPTH+1
- Derived localparams: ADDR_WIDTH = clog2(DEPTH); CNT_WIDTH = clog2(DEPTH+2)

- clk  in  1  single clock; all logic on rising edge
- reset  in  1  synchronous, active-high
- if_write_ce  in  1  write enable qualifier
- if_write  in  1  write request
- if_din  in  DATA_WIDTH  write data
- if_full_n  out  1  1 = space available
- if_almost_full_n  out  1  0 = watermark reached
- if_read_ce  in  1  read enable qualifier
- if_read  in  1  read request
- if_dout  out  DATA_WIDTH  head-of-queue data
- if_empty_n  out  1  1 = data available
- if_num_data_valid  out  CNT_WIDTH  total words held

## Operation
- push = if_write & if_write_ce & if_full_n; pop = if_read & if_read_ce & if_empty_n. Requests with the flag low are ignored; no state change.
- SRL store: on shift-enable, entry[i+1] ← entry[i], entry[0] ← din. Oldest word at index cnt−1; read address = cnt−1 (0 when cnt=0, data don't-care).
- cnt (0..DEPTH): +1 on push only, −1 on SRL drain only, unchanged when both occur.
- OUT_REG=0: SRL drain = pop. if_dout = entry[cnt−1]; if_empty_n = (cnt≠0); capacity DEPTH.
- OUT_REG=1: out_valid/out_data register. Drain occurs when cnt≠0 and (out_valid=0 or pop): out_data ← entry[cnt−1], out_valid ← 1. Pop with no drain: out_valid ← 0. if_dout = out_data; if_empty_n = out_valid; capacity DEPTH+1.
- if_full_n = (cnt≠DEPTH); if_almost_full_n = (cnt < DEPTH−AF_MARGIN). Both are decoded from the registered cnt, with no combinational path from request inputs.
- if_num_data_valid = cnt + out_valid (out_valid≡0 when OUT_REG=0).
- Push and pop in the same cycle when full: the pop does not free space for the push in that cycle. The push is refused because if_full_n=0.

## Timing
- Reset values: cnt=0, out_valid=0, out_data=0, if_full_n=1, if_almost_full_n=1, if_empty_n=0, if_num_data_valid=0. SRL contents are not reset.
- Reset mid-operation empties the FIFO at the next edge. Pushes/pops in the reset cycle are discarded.
- Write-to-read latency, OUT_REG=0: a push at edge t makes if_empty_n=1 after t, with if_dout valid.
- Write-to-read latency, OUT_REG=1: a push at edge t into an empty FIFO makes if_empty_n=1 after t+1.
- Full: a push at edge t bringing cnt to DEPTH makes if_full_n=0 after t. A pop at edge t' (drain, OUT_REG=1) makes if_full_n=1 after t'.
- Sustained throughput is 1 word/cycle with simultaneous push/pop in both modes, with no bubbles.

## Structure
- Package linear_layer_fifo_pkg holds the clog2 function and the CNT_WIDTH/ADDR_WIDTH derivation helpers.
- Sub-module linear_layer_srl_store holds the storage only: we, addr, din, dout; DEPTH/DATA_WIDTH params; no reset.
- The top level holds the counter, flags, the output-register stage (generate on OUT_REG) and the count output.

## Test plan
- Reset with DEPTH=17, OUT_REG=0 -> flags 1/1/0, count 0. Push 0x01..0x11 -> if_full_n=0 after 17th push. if_almost_full_n=0 from count 15. 18th push ignored. Pops return 0x01..0x11 in order.
- Simultaneous push/pop at count 5, for 100 cycles -> count stays 5, output sequence is in order with no loss.
- OUT_REG=1: single push 0xA5 into empty -> if_empty_n rises 2 cycles after push. Fill to capacity -> 18 words accepted, count 18.
- Push and pop both requested while full (OUT_REG=0) -> pop succeeds, push refused, count 16.
- Reset asserted at count 9 during a push -> next cycle count 0, empty_n 0, full_n 1. Subsequent push/pop of 0x3C round-trips.
- Random push/pop with both CE qualifiers toggling, DEPTH=2 and DEPTH=32, both OUT_REG values -> scoreboard matches, count never exceeds capacity.
